layer_blitter: RTL and testbench
================================

Name: layer_blitter

Overview:
- Parametrised successor to the fixed-layer sprite compositor.
- Given a per-frame list of NUM_SPR sprite descriptors, it optionally fills the back frame buffer with the background index, then blits each enabled sprite in ascending priority. Each sprite is read from the packed sprite ROM, with transparent pixels keyed out and off-screen pixels clipped.
- Sits between the game-object modules (descriptor producers) and the double-buffered frame buffer; the palette and VGA path are unchanged.

Parameters:
- NUM_SPR, 8, number of sprite descriptor slots; slot 0 is drawn first, the highest slot wins.
- IDX_W, 4, colour-index width in bits.
- WORD_W, 16, ROM word width; PPW = WORD_W/IDX_W must be a power of two.
- PIX_AW, 18, pixel address width; ROM_AW = PIX_AW - log2(PPW).
- X_W, 10, screen/sprite X width.
- Y_W, 10, screen/sprite Y width.
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- TRANSP_IDX, 0, transparent colour index.
- BG_IDX, 4, background fill index.

Ports:
- Clk50  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: latch descriptors and render one frame.
- clear_en  in  1  sampled at start; 1 = background fill pass first.
- spr_en  in  NUM_SPR  per-slot enable.
- spr_x  in  NUM_SPR*X_W  top-left X; slot i occupies bits [i*X_W +: X_W]. Same packing for spr_y, spr_w, spr_h, spr_base.
- spr_y  in  NUM_SPR*Y_W  top-left Y.
- spr_w  in  NUM_SPR*X_W  width in pixels.
- spr_h  in  NUM_SPR*Y_W  height in pixels.
- spr_base  in  NUM_SPR*PIX_AW  ROM pixel address of the sprite's first pixel.
- rom_addr  out  ROM_AW  word address to the sprite ROM.
- rom_q  in  WORD_W  ROM data, valid exactly 1 cycle after rom_addr.
- fb_we  out  1  frame buffer write strobe.
- fb_x  out  X_W  write X.
- fb_y  out  Y_W  write Y.
- fb_data  out  IDX_W  write colour index.
- buf_sel  out  1  back-buffer select; toggles when a frame completes.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset (asynchronous): state IDLE; rom_addr, fb_we, fb_x, fb_y, fb_data, busy, done, buf_sel all 0.
- Reset mid-frame: abort immediately. fb_we drops to 0 and no done pulse is issued. buf_sel is forced to 0 like every other output.
- FSM states: IDLE, CLEAR, SETUP, BLIT, DRAIN, FIN.
- IDLE:
  - start=1 latches all descriptors and clear_en, then moves to CLEAR if clear_en=1, else SETUP with slot=0.
  - start while busy is ignored and has no effect on the latched descriptors.
- CLEAR:
  - Writes one pixel per cycle in raster order: x 0..SCREEN_W-1 inner, y 0..SCREEN_H-1 outer.
  - fb_data = BG_IDX, fb_we = 1 for every pixel.
  - After pixel (SCREEN_W-1, SCREEN_H-1), go to SETUP with slot=0.
- SETUP (1 cycle per slot):
  - Slot skipped (slot+1) if spr_en=0, w=0 or h=0.
  - Otherwise go to BLIT with row=0, col=0.
  - Once slot reaches NUM_SPR, go to DRAIN.
- BLIT (1 pixel per cycle, 2-stage pipeline):
  - Stage 0: p = base + row*w + col; rom_addr = p >> log2(PPW); sub = p mod PPW.
  - Stage 1, one cycle later: select the pixel MSB-first, i.e. sub=0 is rom_q[WORD_W-1 -: IDX_W].
  - The output registers update the cycle after stage 1. rom_addr to fb_we latency is therefore 2 cycles.
  - fb_we = 1 only if the pixel != TRANSP_IDX and X+col < SCREEN_W and Y+row < SCREEN_H. Sums are computed one bit wider so wrap-around never produces a false hit.
  - fb_x/fb_y/fb_data still update when fb_we = 0.
  - After (w-1, h-1), return to SETUP with slot+1. The pipeline keeps flowing, with no bubble between sprites.
- DRAIN: wait until the pipeline is empty (2 cycles).
- FIN: done = 1 for 1 cycle, buf_sel toggles in the same cycle, busy drops to 0, go to IDLE.
- Multiplication: row*w is computed at PIX_AW bits; overflow is truncated mod 2^PIX_AW.
- Overlap: later slots overwrite earlier ones. No read-back is performed.

Test Plan:
- Reset check: assert Reset asynchronously mid-CLEAR -> all outputs 0 on the same edge, no done pulse, buf_sel = 0.
- Background fill: SCREEN_W=8, SCREEN_H=4, clear_en=1, no sprites -> exactly 32 writes of data 4, x 0..7 for each y 0..3, then done; buf_sel goes 0 to 1; busy is low after done.
- Single sprite: slot0 at (2,1), w=4, h=2, base=8; ROM word 2 = 16'h1023, word 3 = 16'h0045 -> rom_addr sequence 2,2,2,2,3,3,3,3; writes (2,1)=1, (4,1)=2, (5,1)=3, (4,2)=4, (5,2)=5; no write at (3,1), (2,2) or (3,2).
- Priority: slots 0 and 5 both opaque 2x1 at (0,0), with index 7 and index 9 respectively -> (0,0) and (1,0) are written with 7, then later with 9.
- Clipping: SCREEN_W=8, sprite at x=6, w=4, h=1, all opaque -> writes only at x=6 and x=7; column widths are correct, with no wrap to x=0 or x=1.
- Handshake: second start pulse 3 cycles after the first while busy, with changed descriptors -> ignored; output is identical to the first frame; exactly one done pulse.

Source files
------------

// File: rtl/layer_blitter.sv
// layer_blitter: optional background fill, then priority-ordered sprite blits from a packed ROM
// into the back frame buffer, with colour keying and screen clipping.
module layer_blitter #(
  parameter int NUM_SPR = 8,
  parameter int IDX_W = 4,
  parameter int WORD_W = 16,
  parameter int PIX_AW = 18,
  parameter int X_W = 10,
  parameter int Y_W = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int TRANSP_IDX = 0,
  parameter int BG_IDX = 4
) (
  input  logic Clk50,
  input  logic Reset,
  input  logic start,
  input  logic clear_en,
  input  logic [NUM_SPR-1:0] spr_en,
  input  logic [NUM_SPR*X_W-1:0] spr_x,
  input  logic [NUM_SPR*Y_W-1:0] spr_y,
  input  logic [NUM_SPR*X_W-1:0] spr_w,
  input  logic [NUM_SPR*Y_W-1:0] spr_h,
  input  logic [NUM_SPR*PIX_AW-1:0] spr_base,
  output logic [PIX_AW-$clog2(WORD_W/IDX_W)-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_q,
  output logic fb_we,
  output logic [X_W-1:0] fb_x,
  output logic [Y_W-1:0] fb_y,
  output logic [IDX_W-1:0] fb_data,
  output logic buf_sel,
  output logic busy,
  output logic done
);
  localparam int PPW = WORD_W / IDX_W;
  localparam int LG = $clog2(PPW);
  localparam int ROM_AW = PIX_AW - LG;
  localparam int SW = LG > 0 ? LG : 1;
  localparam int SLW = $clog2(NUM_SPR + 1);
  localparam int IW = NUM_SPR > 1 ? $clog2(NUM_SPR) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SETUP, BLIT, DRAIN, FIN} state_t;
  state_t state, nxt;

  logic [NUM_SPR-1:0] en_l;
  logic [NUM_SPR*X_W-1:0] x_l, w_l;
  logic [NUM_SPR*Y_W-1:0] y_l, h_l;
  logic [NUM_SPR*PIX_AW-1:0] base_l;
  logic [SLW-1:0] slot;
  logic [IW-1:0] si;
  logic [X_W-1:0] col, cx, cw, x1, x2;
  logic [Y_W-1:0] row, cy, ch, y1, y2;
  logic [PIX_AW-1:0] cbase, p;
  logic [X_W:0] sx;
  logic [Y_W:0] sy;
  logic [SW-1:0] sub1, sub2;
  logic [IDX_W-1:0] pix;
  logic go, live, slot_end, last_clr, last_col, last_pix, drn, fin_go;
  logic v1, v2, h1, h2;

  assign go = state == IDLE && start;
  assign si = IW'(slot);
  assign cx = x_l[si*X_W +: X_W];
  assign cy = y_l[si*Y_W +: Y_W];
  assign cw = w_l[si*X_W +: X_W];
  assign ch = h_l[si*Y_W +: Y_W];
  assign cbase = base_l[si*PIX_AW +: PIX_AW];
  assign live = en_l[si] && cw != '0 && ch != '0;
  assign slot_end = slot == SLW'(NUM_SPR);
  assign last_clr = col == X_W'(SCREEN_W - 1) && row == Y_W'(SCREEN_H - 1);
  assign last_col = col == cw - 1'b1;
  assign last_pix = last_col && row == ch - 1'b1;
  assign fin_go = state == DRAIN && drn;
  assign p = cbase + PIX_AW'(row) * PIX_AW'(cw) + PIX_AW'(col);
  // one extra bit so a sprite hanging past the last coordinate never wraps onto the screen
  assign sx = {1'b0, cx} + {1'b0, col};
  assign sy = {1'b0, cy} + {1'b0, row};
  assign pix = IDX_W'(rom_q >> (IDX_W * (PPW - 1 - int'(sub2))));

  always_ff @(posedge Clk50)
    if (go) begin
      en_l <= spr_en;
      x_l <= spr_x;
      y_l <= spr_y;
      w_l <= spr_w;
      h_l <= spr_h;
      base_l <= spr_base;
    end

  always_ff @(posedge Clk50 or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? (clear_en ? CLEAR : SETUP) : IDLE;
      CLEAR: nxt = last_clr ? SETUP : CLEAR;
      SETUP: nxt = slot_end ? DRAIN : live ? BLIT : SETUP;
      BLIT: nxt = last_pix ? SETUP : BLIT;
      DRAIN: nxt = drn ? FIN : DRAIN;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk50 or posedge Reset)
    if (Reset) begin
      slot <= '0;
      row <= '0;
      col <= '0;
      drn <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      buf_sel <= 1'b0;
    end else begin
      done <= fin_go;
      busy <= go | (busy & ~fin_go);
      buf_sel <= buf_sel ^ fin_go;
      drn <= state == DRAIN && !drn;
      case (state)
        IDLE: begin
          slot <= '0;
          row <= '0;
          col <= '0;
        end
        CLEAR: begin
          col <= col == X_W'(SCREEN_W - 1) ? '0 : col + 1'b1;
          row <= col == X_W'(SCREEN_W - 1) ? row + 1'b1 : row;
        end
        SETUP: begin
          slot <= slot_end || live ? slot : slot + 1'b1;
          row <= '0;
          col <= '0;
        end
        BLIT: begin
          col <= last_col ? '0 : col + 1'b1;
          row <= last_col ? row + 1'b1 : row;
          slot <= last_pix ? slot + 1'b1 : slot;
        end
        default: ;
      endcase
    end

  always_ff @(posedge Clk50 or posedge Reset)
    if (Reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      h1 <= 1'b0;
      h2 <= 1'b0;
      sub1 <= '0;
      sub2 <= '0;
      x1 <= '0;
      x2 <= '0;
      y1 <= '0;
      y2 <= '0;
      rom_addr <= '0;
      fb_we <= 1'b0;
      fb_x <= '0;
      fb_y <= '0;
      fb_data <= '0;
    end else begin
      v1 <= state == BLIT;
      h1 <= sx < (X_W+1)'(SCREEN_W) && sy < (Y_W+1)'(SCREEN_H);
      sub1 <= SW'(p % PPW);
      x1 <= sx[X_W-1:0];
      y1 <= sy[Y_W-1:0];
      rom_addr <= state == BLIT ? ROM_AW'(p >> LG) : rom_addr;
      v2 <= v1;
      h2 <= h1;
      sub2 <= sub1;
      x2 <= x1;
      y2 <= y1;
      fb_we <= v2 ? h2 && pix != IDX_W'(TRANSP_IDX) : state == CLEAR;
      fb_x <= v2 ? x2 : state == CLEAR ? col : fb_x;
      fb_y <= v2 ? y2 : state == CLEAR ? row : fb_y;
      fb_data <= v2 ? pix : state == CLEAR ? IDX_W'(BG_IDX) : fb_data;
    end
endmodule

// File: tb/tb_layer_blitter.sv
// tb_layer_blitter: directed and random frames, each checked every cycle against a frame model
// that derives the expected write stream and timing from descriptors and ROM contents.
module tb_layer_blitter;
  localparam int NS = 8, PA = 10, SW = 8, SH = 4, RA = 8, DEPTH = 2048;

  logic clk = 0, rst = 0, start = 0, clear_en = 0;
  logic [NS-1:0] spr_en;
  logic [NS*10-1:0] spr_x, spr_y, spr_w, spr_h;
  logic [NS*PA-1:0] spr_base;
  logic [RA-1:0] rom_addr;
  logic [15:0] rom_q;
  logic fb_we, buf_sel, busy, done;
  logic [9:0] fb_x, fb_y;
  logic [3:0] fb_data;
  logic [15:0] rom_mem [256];

  layer_blitter #(.NUM_SPR(NS), .IDX_W(4), .WORD_W(16), .PIX_AW(PA), .X_W(10), .Y_W(10),
    .SCREEN_W(SW), .SCREEN_H(SH), .TRANSP_IDX(0), .BG_IDX(4)) dut (
    .Clk50(clk), .Reset(rst), .start(start), .clear_en(clear_en), .spr_en(spr_en),
    .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h), .spr_base(spr_base),
    .rom_addr(rom_addr), .rom_q(rom_q), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
    .fb_data(fb_data), .buf_sel(buf_sel), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  int d_en[NS], d_x[NS], d_y[NS], d_w[NS], d_h[NS], d_b[NS];
  bit e_we[DEPTH], e_pv[DEPTH], e_rv[DEPTH];
  int e_x[DEPTH], e_y[DEPTH], e_d[DEPTH], e_ra[DEPTH];
  int done_off, k, vec = 0, err = 0, n_done = 0, nd;
  bit armed = 0, e_buf = 0;
  int wx[$], wy[$], wd[$], ra[$];

  task automatic chk(input string n, input int a, input int e);
    vec++;
    if (a != e) begin
      err++;
      $display("FAIL %s cycle=%0d got %0d expected %0d", n, k, a, e);
    end
  endtask

  task automatic put(input int c, input bit we, input int x, input int y, input int d);
    e_pv[c] = 1; e_we[c] = we; e_x[c] = x; e_y[c] = y; e_d[c] = d;
  endtask

  // frame timeline: 1 cycle per clear pixel, 1 per slot visit, 1 per sprite pixel, one
  // final slot visit, 2 drain cycles, then done; blit writes land 3 cycles after issue
  task automatic build(input bit clr);
    int c, p, pix;
    for (int i = 0; i < DEPTH; i++) begin e_we[i] = 0; e_pv[i] = 0; e_rv[i] = 0; end
    c = 1;
    if (clr)
      for (int y = 0; y < SH; y++)
        for (int x = 0; x < SW; x++) begin put(c + 1, 1, x, y, 4); c++; end
    for (int s = 0; s < NS; s++) begin
      c++;
      if (d_en[s] != 0 && d_w[s] != 0 && d_h[s] != 0)
        for (int r = 0; r < d_h[s]; r++)
          for (int q = 0; q < d_w[s]; q++) begin
            p = (d_b[s] + r * d_w[s] + q) % 1024;
            pix = int'((rom_mem[p / 4] >> (12 - 4 * (p % 4))) & 16'hf);
            e_rv[c + 1] = 1; e_ra[c + 1] = p / 4;
            put(c + 3, pix != 0 && d_x[s] + q < SW && d_y[s] + r < SH,
                (d_x[s] + q) % 1024, (d_y[s] + r) % 1024, pix);
            c++;
          end
    end
    done_off = c + 3;
  endtask

  task automatic pack();
    for (int s = 0; s < NS; s++) begin
      spr_en[s] = d_en[s] != 0;
      spr_x[s*10 +: 10] = 10'(d_x[s]);
      spr_y[s*10 +: 10] = 10'(d_y[s]);
      spr_w[s*10 +: 10] = 10'(d_w[s]);
      spr_h[s*10 +: 10] = 10'(d_h[s]);
      spr_base[s*PA +: PA] = PA'(d_b[s]);
    end
  endtask

  task automatic clear_all();
    for (int s = 0; s < NS; s++) begin
      d_en[s] = 0; d_x[s] = 0; d_y[s] = 0; d_w[s] = 0; d_h[s] = 0; d_b[s] = 0;
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (done) n_done++;
    if (armed) begin
      k++;
      chk("fb_we", fb_we, e_we[k]);
      chk("busy", busy, k < done_off);
      chk("done", done, k == done_off);
      chk("buf_sel", buf_sel, (k >= done_off) ? !e_buf : e_buf);
      if (e_pv[k]) begin
        chk("fb_x", fb_x, e_x[k]);
        chk("fb_y", fb_y, e_y[k]);
        chk("fb_data", fb_data, e_d[k]);
      end
      if (e_rv[k]) begin
        chk("rom_addr", rom_addr, e_ra[k]);
        ra.push_back(rom_addr);
      end
      if (fb_we) begin wx.push_back(fb_x); wy.push_back(fb_y); wd.push_back(fb_data); end
      if (k >= done_off) begin armed = 0; e_buf = !e_buf; end
    end
  end

  task automatic launch(input bit clr);
    build(clr);
    pack();
    wx.delete(); wy.delete(); wd.delete(); ra.delete();
    @(negedge clk);
    clear_en = clr; start = 1; k = 0; armed = 1;
    @(negedge clk);
    start = 0; clear_en = !clr;
  endtask

  task automatic run(input bit clr, input bit dbl);
    launch(clr);
    if (dbl) begin
      repeat (2) @(negedge clk);
      spr_x = ~spr_x; spr_en = ~spr_en; spr_base = ~spr_base; start = 1;
      @(negedge clk);
      start = 0;
    end
    for (int i = 0; i < DEPTH && armed; i++) @(negedge clk);
    if (armed) begin chk("frame_timeout", armed, 0); armed = 0; end
    repeat (2) @(negedge clk);
  endtask

  task automatic outs_zero(input string n);
    chk({n, "_we"}, fb_we, 0);
    chk({n, "_x"}, fb_x, 0);
    chk({n, "_y"}, fb_y, 0);
    chk({n, "_data"}, fb_data, 0);
    chk({n, "_rom"}, rom_addr, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_buf"}, buf_sel, 0);
  endtask

  task automatic expect_writes(input string n, input int cnt, input int lx[], input int ly[], input int ld[]);
    chk({n, "_count"}, wx.size(), cnt);
    for (int i = 0; i < cnt && i < wx.size(); i++) begin
      chk({n, "_x"}, wx[i], lx[i]);
      chk({n, "_y"}, wy[i], ly[i]);
      chk({n, "_data"}, wd[i], ld[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int rx[], rdat[];
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'($urandom);
    clear_all();
    pack();
    #1 rst = 1;
    repeat (3) @(negedge clk);
    outs_zero("reset");
    rst = 0;
    repeat (2) @(negedge clk);

    run(1, 0);
    chk("fill_count", wx.size(), 32);
    for (int i = 0; i < 32 && i < wx.size(); i++) begin
      chk("fill_x", wx[i], i % 8);
      chk("fill_y", wy[i], i / 8);
      chk("fill_data", wd[i], 4);
    end
    chk("fill_buf_sel", buf_sel, 1);
    chk("fill_busy", busy, 0);

    launch(1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3;
    armed = 0; rst = 1;
    #1;
    outs_zero("midreset");
    nd = n_done;
    repeat (3) @(negedge clk);
    rst = 0; e_buf = 0;
    repeat (4) @(negedge clk);
    chk("midreset_no_done", n_done, nd);
    chk("midreset_idle_busy", busy, 0);
    chk("midreset_idle_we", fb_we, 0);

    clear_all();
    rom_mem[2] = 16'h1023; rom_mem[3] = 16'h0045;
    d_en[0] = 1; d_x[0] = 2; d_y[0] = 1; d_w[0] = 4; d_h[0] = 2; d_b[0] = 8;
    run(0, 0);
    expect_writes("single", 5, '{2, 4, 5, 4, 5}, '{1, 1, 1, 2, 2}, '{1, 2, 3, 4, 5});
    rx = '{2, 2, 2, 2, 3, 3, 3, 3};
    chk("single_rom_count", ra.size(), 8);
    for (int i = 0; i < 8 && i < ra.size(); i++) chk("single_rom_seq", ra[i], rx[i]);

    nd = n_done;
    run(0, 1);
    expect_writes("handshake", 5, '{2, 4, 5, 4, 5}, '{1, 1, 1, 2, 2}, '{1, 2, 3, 4, 5});
    chk("handshake_done_pulses", n_done - nd, 1);

    clear_all();
    rom_mem[4] = 16'h7700; rom_mem[5] = 16'h9900;
    d_en[0] = 1; d_w[0] = 2; d_h[0] = 1; d_b[0] = 16;
    d_en[5] = 1; d_w[5] = 2; d_h[5] = 1; d_b[5] = 20;
    run(0, 0);
    expect_writes("priority", 4, '{0, 1, 0, 1}, '{0, 0, 0, 0}, '{7, 7, 9, 9});

    clear_all();
    rom_mem[6] = 16'hABCD;
    d_en[0] = 1; d_x[0] = 6; d_w[0] = 4; d_h[0] = 1; d_b[0] = 24;
    run(0, 0);
    rdat = '{10, 11};
    expect_writes("clip", 2, '{6, 7}, '{0, 0}, rdat);

    for (int i = 0; i < 256; i++)
      for (int n = 0; n < 4; n++)
        rom_mem[i][n*4 +: 4] = ($urandom % 4 == 0) ? 4'h0 : 4'($urandom);
    for (int f = 0; f < 25; f++) begin
      for (int s = 0; s < NS; s++) begin
        d_en[s] = ($urandom % 4 != 0) ? 1 : 0;
        d_x[s] = ($urandom % 8 == 0) ? 1018 + int'($urandom % 6) : int'($urandom % 12);
        d_y[s] = ($urandom % 8 == 0) ? 1020 + int'($urandom % 4) : int'($urandom % 7);
        d_w[s] = int'($urandom % 6);
        d_h[s] = int'($urandom % 5);
        d_b[s] = int'($urandom % 1024);
      end
      run(1'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
